// File: rtl/regfile_pkg.sv
// Shared widths, FSM encoding and requester index type for the
// register-file arbiter.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on
// contention the requester that did not win last time is granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 2R/1W register file.
// Optional RF_ZERO_GUARD_EN makes address 0 read as zero and ignore writes.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_waddr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [ADDR_W-1:0] req0_raddr1,
  input  logic [ADDR_W-1:0] req0_raddr2,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata1,
  output logic [DATA_W-1:0] resp0_rdata2,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_waddr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [ADDR_W-1:0] req1_raddr1,
  input  logic [ADDR_W-1:0] req1_raddr2,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata1,
  output logic [DATA_W-1:0] resp1_rdata2,

  output logic              rf_re,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  state_e   state;
  req_idx_t last_grant;
  req_idx_t owner;
  logic     live;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              go;
  req_idx_t          sel;
  logic              s_we;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic [ADDR_W-1:0] s_raddr1;
  logic [ADDR_W-1:0] s_raddr2;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // No grants until one full edge has passed since reset release
  assign req = {req1_valid, req0_valid}
             & {2{live && (state == IDLE)}};

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign go       = |grant;
  assign sel      = grant[1];
  assign s_we     = sel ? req1_we     : req0_we;
  assign s_waddr  = sel ? req1_waddr  : req0_waddr;
  assign s_wdata  = sel ? req1_wdata  : req0_wdata;
  assign s_raddr1 = sel ? req1_raddr1 : req0_raddr1;
  assign s_raddr2 = sel ? req1_raddr2 : req0_raddr2;

`ifdef RF_ZERO_GUARD_EN
  logic z1;
  logic z2;

  assign wr_ok = (s_waddr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z1 <= 1'b0;
      z2 <= 1'b0;
    end else if (go && !s_we) begin
      z1 <= (s_raddr1 == '0);
      z2 <= (s_raddr2 == '0);
    end
  end

  assign rd1 = z1 ? '0 : rf_rdata1;
  assign rd2 = z2 ? '0 : rf_rdata2;
`else
  assign wr_ok = 1'b1;
  assign rd1   = rf_rdata1;
  assign rd2   = rf_rdata2;
`endif

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign rf_we     = go && s_we && wr_ok;
  assign rf_re     = go && !s_we;
  assign rf_waddr  = s_waddr;
  assign rf_wdata  = s_wdata;
  assign rf_raddr1 = s_raddr1;
  assign rf_raddr2 = s_raddr2;

  assign resp0_valid  = (state == RD_WAIT) && (owner == 1'b0);
  assign resp1_valid  = (state == RD_WAIT) && (owner == 1'b1);
  assign resp0_rdata1 = rd1;
  assign resp0_rdata2 = rd2;
  assign resp1_rdata1 = rd1;
  assign resp1_rdata2 = rd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      live       <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (go) begin
            last_grant <= sel;
            if (!s_we) begin
              owner <= sel;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
